// File: rtl/otn_frame_receiver.sv
// Far-end OTN frame receiver: UART line deserialiser, FAS lock, CRC-8 check,
// payload buffer drained over valid/ready, and a serial ACK/NAK reply line.
module otn_frame_receiver #(
  parameter int unsigned PYLD_LEN = 16,
  parameter logic [7:0]  FAS0     = 8'hF6,
  parameter logic [7:0]  FAS1     = 8'h28,
  parameter logic [7:0]  CRC_POLY = 8'h07,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clk_en_16x,
  input  logic       i_otn_rx_data,
  output logic       o_otn_tx_ack,
  input  logic       i_arq_en,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_pyld_data_ready,
  output logic [7:0] o_crc_val,
  output logic       o_crc_err,
  output logic       o_overrun,
  output logic [2:0] o_frame_state
);

  localparam int unsigned PTR_W = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PYLD_LEN - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_FAS   = 3'd1,
    ST_PYLD  = 3'd2,
    ST_CRC   = 3'd3,
    ST_DRAIN = 3'd4
  } frame_state_t;

  // MSB-first CRC-8 over one byte, init/final handled by the caller
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // ---------------- line receiver ----------------
  rx_state_t    rx_state, rx_state_nxt;
  logic         rx_s1, rx_s2, rx_s3;
  logic [3:0]   rx_tick;
  logic [2:0]   rx_bit;
  logic [7:0]   rx_shift;
  logic         rx_mid_c;
  logic         byte_stb;
  logic         frame_err;
  logic [7:0]   byte_data;

  // Start bit is re-checked at its middle (8 ticks), data/stop every 16 ticks
  assign rx_mid_c = i_clk_en_16x && (rx_tick == ((rx_state == RX_START) ? 4'd7 : 4'd15));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= i_otn_rx_data;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_s3) rx_state_nxt = RX_START;
      RX_START: if (rx_mid_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_mid_c && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_mid_c) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_tick   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      byte_data <= '0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_state == RX_IDLE || rx_mid_c) rx_tick <= '0;
      else if (i_clk_en_16x)               rx_tick <= rx_tick + 4'd1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_mid_c) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_state == RX_STOP && rx_mid_c) begin
        byte_data <= rx_shift;
        if (rx_s2) byte_stb  <= 1'b1;
        else       frame_err <= 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  frame_state_t     state, state_nxt;
  logic [7:0]       pyld_mem [PYLD_LEN];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt_c;
  logic [7:0]       crc_reg;
  logic             buf_we_c;
  logic             crc_clr_c;
  logic             crc_chk_c;
  logic             tx_req_c;
  logic [7:0]       tx_byte_c;

  assign o_frame_state = state;
  assign rd_nxt_c      = rd_ptr + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_we_c  = 1'b0;
    crc_clr_c = 1'b0;
    crc_chk_c = 1'b0;
    tx_req_c  = 1'b0;
    tx_byte_c = ACK_BYTE;
    unique case (state)
      ST_HUNT: if (byte_stb && byte_data == FAS0) state_nxt = ST_FAS;
      ST_FAS: if (byte_stb) begin
        if (byte_data == FAS1) begin
          state_nxt = ST_PYLD;
          crc_clr_c = 1'b1;
        end else if (byte_data != FAS0) begin
          state_nxt = ST_HUNT;
        end
      end
      ST_PYLD: if (byte_stb) begin
        buf_we_c = 1'b1;
        if (wr_ptr == LAST_IDX) state_nxt = ST_CRC;
      end
      ST_CRC: if (byte_stb) begin
        crc_chk_c = 1'b1;
        if (i_arq_en) begin
          tx_req_c = 1'b1;
          if (byte_data == crc_reg) begin
            state_nxt = ST_DRAIN;
          end else begin
            tx_byte_c = NAK_BYTE;
            state_nxt = ST_HUNT;
          end
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (o_pyld_data_valid && i_pyld_data_ready && rd_ptr == LAST_IDX) state_nxt = ST_HUNT;
      default: state_nxt = ST_HUNT;
    endcase
    // A buffered good frame is still delivered if the line glitches while draining
    if (frame_err && state != ST_DRAIN) state_nxt = ST_HUNT;
  end

  always_ff @(posedge i_clk) begin
    if (buf_we_c) pyld_mem[wr_ptr] <= byte_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_reg           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      o_crc_val         <= '0;
      o_crc_err         <= 1'b0;
      o_overrun         <= 1'b0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
    end else begin
      o_crc_err <= 1'b0;
      if (crc_clr_c) begin
        crc_reg <= '0;
        wr_ptr  <= '0;
      end
      if (buf_we_c) begin
        crc_reg <= crc8_byte(crc_reg, byte_data);
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (crc_chk_c) begin
        o_crc_val <= crc_reg;
        o_crc_err <= (byte_data != crc_reg);
        rd_ptr    <= '0;
      end
      if (state == ST_DRAIN) begin
        if (byte_stb) o_overrun <= 1'b1;
        if (!o_pyld_data_valid) begin
          o_pyld_data_valid <= 1'b1;
          o_pyld_data       <= pyld_mem[rd_ptr];
        end else if (i_pyld_data_ready) begin
          if (rd_ptr == LAST_IDX) begin
            o_pyld_data_valid <= 1'b0;
          end else begin
            rd_ptr      <= rd_nxt_c;
            o_pyld_data <= pyld_mem[rd_nxt_c];
          end
        end
      end
    end
  end

  // ---------------- reply transmitter ----------------
  logic       tx_busy;
  logic [8:0] tx_shift;
  logic [3:0] tx_tick;
  logic [3:0] tx_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_busy      <= 1'b0;
      tx_shift     <= '0;
      tx_tick      <= '0;
      tx_bit       <= '0;
      o_otn_tx_ack <= 1'b1;
    end else if (!tx_busy) begin
      if (tx_req_c) begin
        tx_busy      <= 1'b1;
        tx_shift     <= {1'b1, tx_byte_c};
        tx_tick      <= '0;
        tx_bit       <= '0;
        o_otn_tx_ack <= 1'b0;
      end
    end else if (i_clk_en_16x) begin
      if (tx_tick == 4'd15) begin
        tx_tick <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy      <= 1'b0;
          o_otn_tx_ack <= 1'b1;
        end else begin
          o_otn_tx_ack <= tx_shift[0];
          tx_shift     <= {1'b1, tx_shift[8:1]};
          tx_bit       <= tx_bit + 4'd1;
        end
      end else begin
        tx_tick <= tx_tick + 4'd1;
      end
    end
  end

endmodule
